// File: rtl/fp_mul_result_queue.sv
// rtl/fp_mul_result_queue.sv - FP32 multiplier result FIFO with sticky exception status, counters and irq

module fp_result_fifo #(
    parameter int DEPTH  = 4,
    parameter int DATA_W = 37
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic [DATA_W-1:0]          s_tdata,
    input  logic                       s_tvalid,
    output logic                       s_tready,
    output logic [DATA_W-1:0]          m_tdata,
    output logic                       m_tvalid,
    input  logic                       m_tready,
    output logic [$clog2(DEPTH):0]     level
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int LVL_W = PTR_W + 1;
    localparam logic [LVL_W-1:0] FULL_LVL = LVL_W'(DEPTH);

    logic [DATA_W-1:0] mem [DEPTH];
    logic [PTR_W-1:0]  wr_ptr;
    logic [PTR_W-1:0]  rd_ptr;
    logic              push;
    logic              pop;

    // Ready depends only on the registered level, so a full queue refuses
    // input even when the consumer pops in the same cycle.
    assign s_tready = (level != FULL_LVL);
    assign m_tvalid = (level != '0);
    assign push     = s_tvalid && s_tready;
    assign pop      = m_tvalid && m_tready;
    assign m_tdata  = m_tvalid ? mem[rd_ptr] : '0;

    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= s_tdata;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            case ({push, pop})
                2'b10:   level <= level + LVL_W'(1);
                2'b01:   level <= level - LVL_W'(1);
                default: level <= level;
            endcase
        end
    end
endmodule

module fp_mul_result_queue #(
    parameter int DEPTH = 4,
    parameter int CNT_W = 16
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic [31:0]                in_result,
    input  logic [4:0]                 in_flags,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [31:0]                out_result,
    output logic [4:0]                 out_flags,
    output logic [$clog2(DEPTH):0]     level,
    output logic [4:0]                 sticky_flags,
    input  logic                       clear_sticky,
    input  logic [4:0]                 irq_mask,
    output logic                       irq,
    output logic [CNT_W-1:0]           op_count,
    output logic [CNT_W-1:0]           exc_count
);
    logic [36:0] head_tdata;
    logic        push;
    logic        exc_hit;
    logic [4:0]  sticky_next;

    fp_result_fifo #(
        .DEPTH  (DEPTH),
        .DATA_W (37)
    ) u_fifo (
        .clk      (clk),
        .reset    (reset),
        .s_tdata  ({in_result, in_flags}),
        .s_tvalid (in_valid),
        .s_tready (in_ready),
        .m_tdata  (head_tdata),
        .m_tvalid (out_valid),
        .m_tready (out_ready),
        .level    (level)
    );

    assign out_result = head_tdata[36:5];
    assign out_flags  = head_tdata[4:0];

    assign push = in_valid && in_ready;
    // Flag order {inf, nan, zero, overflow, underflow}; zero is not an exception.
    assign exc_hit = in_flags[4] | in_flags[3] | in_flags[1] | in_flags[0];

    always_comb begin
        sticky_next = clear_sticky ? 5'b0 : sticky_flags;
        if (push) begin
            sticky_next = sticky_next | in_flags;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            sticky_flags <= '0;
            irq          <= 1'b0;
            op_count     <= '0;
            exc_count    <= '0;
        end else begin
            sticky_flags <= sticky_next;
            irq          <= |(sticky_next & irq_mask);
            if (push && (op_count != '1)) begin
                op_count <= op_count + CNT_W'(1);
            end
            if (push && exc_hit && (exc_count != '1)) begin
                exc_count <= exc_count + CNT_W'(1);
            end
        end
    end
endmodule

// File: tb/tb_fp_mul_result_queue.sv
// tb/tb_fp_mul_result_queue.sv - scoreboard bench for fp_mul_result_queue
`timescale 1ns/1ps

module tb_fp_mul_result_queue;
    localparam int DEPTH = 4;
    localparam int CNT_W = 4;

    logic        clk = 1'b0;
    logic        reset;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_result;
    logic [4:0]  in_flags;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_result;
    logic [4:0]  out_flags;
    logic [2:0]  level;
    logic [4:0]  sticky_flags;
    logic        clear_sticky;
    logic [4:0]  irq_mask;
    logic        irq;
    logic [CNT_W-1:0] op_count;
    logic [CNT_W-1:0] exc_count;

    typedef struct {
        logic [31:0] res;
        logic [4:0]  flg;
    } ent_t;

    ent_t sb[$];
    int   checks = 0;
    int   errors = 0;

    fp_mul_result_queue #(.DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
        .clk          (clk),
        .reset        (reset),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .in_result    (in_result),
        .in_flags     (in_flags),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .out_result   (out_result),
        .out_flags    (out_flags),
        .level        (level),
        .sticky_flags (sticky_flags),
        .clear_sticky (clear_sticky),
        .irq_mask     (irq_mask),
        .irq          (irq),
        .op_count     (op_count),
        .exc_count    (exc_count)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [31:0] r, input logic [4:0] f, input bit accept);
        ent_t e;
        in_valid  = v;
        in_result = r;
        in_flags  = f;
        if (v && accept) begin
            e.res = r;
            e.flg = f;
            sb.push_back(e);
        end
    endtask

    task automatic do_reset();
        reset        = 1'b1;
        in_valid     = 1'b0;
        clear_sticky = 1'b0;
        repeat (2) @(posedge clk);
        sb.delete();
        #1;
        reset = 1'b0;
    endtask

    // Monitor: the head must match the oldest expected entry every cycle it is valid.
    always @(negedge clk) begin
        if (!reset) begin
            if (out_valid) begin
                if (sb.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_output: got %h with nothing expected", out_result);
                end else begin
                    chk("head_result", out_result, sb[0].res);
                    chk("head_flags", 32'(out_flags), 32'(sb[0].flg));
                    if (out_ready) begin
                        void'(sb.pop_front());
                    end
                end
            end else begin
                chk("idle_result", out_result, 32'h0);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] fill_words [4];
        fill_words[0] = 32'h3F80_0000;
        fill_words[1] = 32'h4000_0000;
        fill_words[2] = 32'h4040_0000;
        fill_words[3] = 32'h4080_0000;

        in_result = '0;
        in_flags  = '0;
        out_ready = 1'b0;
        irq_mask  = '0;
        do_reset();

        @(negedge clk);
        chk("rst_level", 32'(level), 0);
        chk("rst_out_valid", 32'(out_valid), 0);
        chk("rst_sticky", 32'(sticky_flags), 0);
        chk("rst_op", 32'(op_count), 0);
        chk("rst_exc", 32'(exc_count), 0);
        chk("rst_irq", 32'(irq), 0);
        chk("rst_in_ready", 32'(in_ready), 1);
        step();

        // Basic pass-through with one-cycle latency
        out_ready = 1'b1;
        drive(1, 32'h40C0_0000, 5'b00000, 1);
        @(negedge clk);
        chk("pt_pre_valid", 32'(out_valid), 0);
        step();
        drive(0, 0, 0, 0);
        @(negedge clk);
        chk("pt_valid", 32'(out_valid), 1);
        chk("pt_op", 32'(op_count), 1);
        chk("pt_exc", 32'(exc_count), 0);
        step();
        @(negedge clk);
        chk("pt_level", 32'(level), 0);
        step();

        // Fill to full and hold a fifth word under backpressure
        out_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            drive(1, fill_words[i], 5'b00000, 1);
            step();
        end
        drive(1, 32'h40A0_0000, 5'b00000, 0);
        @(negedge clk);
        chk("full_in_ready", 32'(in_ready), 0);
        chk("full_level", 32'(level), 4);
        step();
        @(negedge clk);
        chk("full_hold_level", 32'(level), 4);
        step();
        drive(0, 0, 0, 0);
        out_ready = 1'b1;
        repeat (4) step();
        @(negedge clk);
        chk("drain_level", 32'(level), 0);
        step();

        // Full with simultaneous pop: push refused, then accepted next cycle
        out_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            drive(1, 32'h4100_0000 + 32'(i) * 32'h0010_0000, 5'b00000, 1);
            step();
        end
        drive(1, 32'h4180_0000, 5'b00000, 0);
        out_ready = 1'b1;
        @(negedge clk);
        chk("fp_in_ready", 32'(in_ready), 0);
        step();
        drive(1, 32'h4180_0000, 5'b00000, 1);
        @(negedge clk);
        chk("fp_level_after_pop", 32'(level), 3);
        chk("fp_in_ready_after", 32'(in_ready), 1);
        step();
        drive(0, 0, 0, 0);
        @(negedge clk);
        chk("fp_level_pushpop", 32'(level), 3);
        repeat (3) step();
        @(negedge clk);
        chk("fp_drain_level", 32'(level), 0);
        step();

        // Sticky flags, irq and clear racing a push
        irq_mask = 5'b01000;
        drive(1, 32'h7FC0_0000, 5'b01000, 1);
        @(negedge clk);
        chk("irq_pre", 32'(irq), 0);
        step();
        drive(0, 0, 0, 0);
        @(negedge clk);
        chk("st_sticky", 32'(sticky_flags), 32'b01000);
        chk("st_irq", 32'(irq), 1);
        chk("st_exc", 32'(exc_count), 1);
        step();
        clear_sticky = 1'b1;
        drive(1, 32'h3F80_0000, 5'b00100, 1);
        step();
        clear_sticky = 1'b0;
        drive(0, 0, 0, 0);
        @(negedge clk);
        chk("clr_sticky", 32'(sticky_flags), 32'b00100);
        chk("clr_irq", 32'(irq), 0);
        chk("clr_exc_zero_excluded", 32'(exc_count), 1);
        chk("clr_op", 32'(op_count), 12);
        irq_mask = 5'b00100;
        step();
        @(negedge clk);
        chk("mask_irq", 32'(irq), 1);
        irq_mask = 5'b00000;
        step();

        // Counter saturation at 2^CNT_W - 1
        do_reset();
        out_ready = 1'b1;
        for (int i = 0; i < 20; i++) begin
            drive(1, 32'h4100_0000 + 32'(i), 5'b00010, 1);
            step();
        end
        drive(0, 0, 0, 0);
        step();
        @(negedge clk);
        chk("sat_op", 32'(op_count), 15);
        chk("sat_exc", 32'(exc_count), 15);
        chk("sat_sticky", 32'(sticky_flags), 32'b00010);
        step();
        drive(1, 32'h4200_0000, 5'b00010, 1);
        step();
        drive(0, 0, 0, 0);
        step();
        @(negedge clk);
        chk("sat_hold_op", 32'(op_count), 15);
        chk("sat_hold_exc", 32'(exc_count), 15);
        step();

        // Reset mid-operation discards the queue; push during reset is ignored
        out_ready    = 1'b0;
        clear_sticky = 1'b1;
        drive(1, 32'hC000_0000, 5'b10000, 1);
        step();
        clear_sticky = 1'b0;
        drive(1, 32'hC040_0000, 5'b00000, 1);
        step();
        drive(1, 32'hC080_0000, 5'b00000, 1);
        step();
        drive(0, 0, 0, 0);
        @(negedge clk);
        chk("mid_level", 32'(level), 3);
        chk("mid_sticky", 32'(sticky_flags), 32'b10000);
        step();
        reset = 1'b1;
        drive(1, 32'hDEAD_BEEF, 5'b11111, 0);
        @(posedge clk);
        sb.delete();
        #1;
        reset = 1'b0;
        drive(0, 0, 0, 0);
        @(negedge clk);
        chk("mr_level", 32'(level), 0);
        chk("mr_out_valid", 32'(out_valid), 0);
        chk("mr_sticky", 32'(sticky_flags), 0);
        chk("mr_op", 32'(op_count), 0);
        chk("mr_exc", 32'(exc_count), 0);
        chk("mr_irq", 32'(irq), 0);
        step();
        out_ready = 1'b1;
        drive(1, 32'hC049_0FDB, 5'b00000, 1);
        step();
        drive(0, 0, 0, 0);
        @(negedge clk);
        chk("mr_push_valid", 32'(out_valid), 1);
        chk("mr_push_op", 32'(op_count), 1);
        repeat (2) step();
        chk("sb_empty", 32'(sb.size()), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/fp_mul_result_queue.md
Name: fp_mul_result_queue

Overview:
- Sits directly downstream of the combinational FP32 multiplier.
- Captures each product word together with its 5 exception flags {inf, nan, zero, overflow, underflow} through a valid/ready handshake.
- Buffers captured entries in a small FIFO and presents them to the consumer through a second valid/ready handshake.
- Keeps sticky exception status, operation and exception counters, and a maskable interrupt.

Parameters:
- DEPTH, 4, FIFO entries; must be a power of 2 and at least 2.
- CNT_W, 16, width of op_count and exc_count.

Ports:
- clk  in  1  rising-edge clock.
- reset  in  1  synchronous, active-high reset.
- in_valid  in  1  multiplier result is present.
- in_ready  out  1  queue can accept an entry.
- in_result  in  32  FP32 product.
- in_flags  in  5  {inf, nan, zero, overflow, underflow} from the multiplier.
- out_valid  out  1  head entry is valid.
- out_ready  in  1  consumer takes the head entry.
- out_result  out  32  head FP32 word.
- out_flags  out  5  head flags.
- level  out  $clog2(DEPTH)+1  current occupancy.
- sticky_flags  out  5  OR of the flags of all accepted entries since the last clear.
- clear_sticky  in  1  one-cycle pulse that clears sticky_flags.
- irq_mask  in  5  per-bit enable for irq.
- irq  out  1  registered; high when (sticky_flags & irq_mask) != 0.
- op_count  out  CNT_W  number of accepted entries; saturates.
- exc_count  out  CNT_W  accepted entries with any of inf, nan, overflow or underflow set; saturates. The zero flag is excluded.

Behaviour:
- Clock and reset: single clk domain. Reset is synchronous and active-high.
- Reset values: read and write pointers 0, level 0, out_valid 0, sticky_flags 0, op_count 0, exc_count 0, irq 0. Storage contents are don't-care.
- Push (accept): occurs when in_valid && in_ready.
  - in_ready = (level != DEPTH).
  - in_ready is a function of registered state only. It has no combinational path from out_ready.
  - When full, the queue rejects input even if a pop occurs in the same cycle.
- Pop: occurs when out_valid && out_ready.
  - out_valid = (level != 0).
  - out_result and out_flags are the head storage entry, driven to 0 when out_valid = 0.
- Latency: an entry accepted at edge N is visible on out_* after edge N (one cycle). There is no bypass while empty.
- Simultaneous push and pop (only possible when 0 < level < DEPTH): level is unchanged and both pointers advance.
- Pointers: $clog2(DEPTH) bits, wrapping modulo DEPTH. Level is tracked separately, so full and empty are never ambiguous.
- The head entry and its flags must remain stable while out_valid && !out_ready.
- sticky_flags:
  - next value = (clear_sticky ? 0 : sticky_flags) | (push ? in_flags : 0).
  - A push in the same cycle as clear_sticky sets its flags after the clear.
- irq: registered from next-state sticky_flags & irq_mask, so it rises one cycle after the triggering push. irq_mask changes take effect on the following edge.
- op_count: increments on each push and holds at 2^CNT_W - 1. It is not cleared by clear_sticky.
- exc_count: increments on a push with |in_flags[4], in_flags[3], in_flags[1], in_flags[0]| = 1, and saturates at 2^CNT_W - 1.
- Reset mid-operation: all queued entries are discarded, and out_valid is 0 in the cycle after reset. A push presented during reset is ignored and does not update the counters.
- Inputs sampled while !in_ready are ignored: no counter or sticky update.

Test Plan:
- Basic pass-through:
  - Stimulus: after reset, push 0x40C00000 with flags 00000; out_ready = 1.
  - Required: out_valid = 1 exactly one cycle later with out_result = 0x40C00000, op_count = 1, exc_count = 0, level returns to 0.
- Fill and backpressure:
  - Stimulus: out_ready = 0; push 0x3F800000, 0x40000000, 0x40400000, 0x40800000, then hold in_valid with 0x40A00000.
  - Required: in_ready = 0 with level = 4; the 5th word is not accepted.
  - Then raise out_ready: drain order is exactly those 4 words.
- Full plus pop in the same cycle:
  - Stimulus: level = 4, out_ready = 1, in_valid = 1.
  - Required: pop occurs, push does not, level = 3.
  - Next cycle: push is accepted and level stays at 3.
- Sticky flags and irq:
  - Stimulus: irq_mask = 01000; push 0x7FC00000 with flags 01000.
  - Required: sticky_flags = 01000, irq = 1 one cycle after the push, exc_count = 1.
  - Stimulus: clear_sticky together with a push flagged 00100.
  - Required: sticky_flags = 00100, irq = 0.
- Counter saturation:
  - Stimulus: with CNT_W = 4, run 20 pushes all flagged 00010.
  - Required: op_count = 15, exc_count = 15, and both hold.
- Reset mid-operation:
  - Stimulus: level = 3 and sticky_flags = 10000; assert reset for 1 cycle.
  - Required: level = 0, out_valid = 0, sticky_flags = 0, counters = 0.
  - Next push: appears unchanged at the output.
